// File: rtl/dpfm_pkg.sv
// Shared types and helpers for the dual-port frame monitor.
package dpfm_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      HUNT  = 3'd0,
      SYNC1 = 3'd1,
      LEN   = 3'd2,
      SEQ   = 3'd3,
      PAY   = 3'd4
   } dpfm_state_t;

   // True when addr lies inside either inclusive window.
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] lo0, input logic [31:0] hi0,
                                      input logic [31:0] lo1, input logic [31:0] hi1);
      return ((addr >= lo0) && (addr <= hi0)) || ((addr >= lo1) && (addr <= hi1));
   endfunction

endpackage

// File: rtl/dual_port_frame_monitor_if.sv
// The two DSP write buses into the shared dual-port RAM.
interface dual_port_frame_monitor_if #(
   parameter int AW = 10,
   parameter int DW = 16
) ();
   logic          xzcs_a;
   logic          we_a;
   logic [AW-1:0] addr_a;
   logic [DW-1:0] data_a;
   logic          xzcs_b;
   logic          we_b;
   logic [AW-1:0] addr_b;
   logic [DW-1:0] data_b;

   // DSP side drives the bus
   modport master (output xzcs_a, we_a, addr_a, data_a, xzcs_b, we_b, addr_b, data_b);
   // The monitor only listens
   modport slave  (input  xzcs_a, we_a, addr_a, data_a, xzcs_b, we_b, addr_b, data_b);
endinterface

// File: rtl/dpfm_bus_capture.sv
// One sniffer per DSP bus: synchronises the write strobe, tracks the
// address/data while it is held and emits a one-cycle commit pulse for
// writes that land inside a monitored window.
module dpfm_bus_capture
   import dpfm_pkg::*;
#(
   parameter int            DW      = 16,
   parameter int            AW      = 10,
   parameter logic [AW-1:0] WIN0_LO = 10'h001,
   parameter logic [AW-1:0] WIN0_HI = 10'h01e,
   parameter logic [AW-1:0] WIN1_LO = 10'h101,
   parameter logic [AW-1:0] WIN1_HI = 10'h11e
) (
   input  logic          clk,
   input  logic          iRst_n,
   input  logic          xzcs,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] data,
   output logic          commit,
   output logic [DW-1:0] word
);

   logic          strb_p0, strb_p1, strb_p2;
   logic [AW-1:0] addr_p1;
   logic [DW-1:0] data_p1;

   // Strobe synchroniser, bus tracking while strb_s is high, commit on its falling edge
   always_ff @(posedge clk or negedge iRst_n) begin
      if (!iRst_n) begin
         strb_p0 <= 1'b0;
         strb_p1 <= 1'b0;
         strb_p2 <= 1'b0;
         addr_p1 <= '0;
         data_p1 <= '0;
         commit  <= 1'b0;
         word    <= '0;
      end else begin
         // --- stage p0/p1: two-flop synchroniser on the raw strobe
         strb_p0 <= ~xzcs & ~we;
         strb_p1 <= strb_p0;
         // --- stage p2: delayed copy for edge detection; bus sampled while strobe is seen
         strb_p2 <= strb_p1;
         if (strb_p1) begin
            addr_p1 <= addr;
            data_p1 <= data;
         end
         // --- stage p3: commit one cycle after strb_s falls
         commit <= strb_p2 & ~strb_p1 &
                   in_window(32'(addr_p1), 32'(WIN0_LO), 32'(WIN0_HI),
                             32'(WIN1_LO), 32'(WIN1_HI));
         word   <= data_p1;
      end
   end

endmodule

// File: rtl/dual_port_frame_monitor.sv
// Passive frame parser on the two DSP RAM write buses: arbitrates the two
// committed-word streams, parses SYNC/SYNC/LEN/SEQ/payload frames and
// reports continuity, match flags, counters and an idle timeout.
module dual_port_frame_monitor
   import dpfm_pkg::*;
#(
   parameter int            DW      = 16,
   parameter int            AW      = 10,
   parameter logic [AW-1:0] WIN0_LO = 10'h001,
   parameter logic [AW-1:0] WIN0_HI = 10'h01e,
   parameter logic [AW-1:0] WIN1_LO = 10'h101,
   parameter logic [AW-1:0] WIN1_HI = 10'h11e,
   parameter logic [DW-1:0] SYNC    = 16'h007e,
   parameter int            MAXLEN  = 26,
   parameter logic [DW-1:0] MATCH0  = 16'h000a,
   parameter logic [DW-1:0] MATCH1  = 16'h000b,
   parameter logic [17:0]   TIMEOUT = 18'd150000,
   parameter int            CNTW    = 16
) (
   input  logic                    clk,
   input  logic                    iRst_n,
   dual_port_frame_monitor_if.slave bus,
   input  logic                    iClr,
   output logic                    oSeqOk,
   output logic                    oMatch0,
   output logic                    oMatch1,
   output logic                    oFrameDone,
   output logic                    oErr,
   output logic [CNTW-1:0]         oFrameCnt,
   output logic [CNTW-1:0]         oErrCnt,
   output logic [STATE_W-1:0]      oState
);

   localparam logic [DW-1:0] MAXLEN_W = DW'(MAXLEN);

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic          vld_a, vld_b;
   logic [DW-1:0] word_a, word_b;

   dpfm_bus_capture #(.DW(DW), .AW(AW), .WIN0_LO(WIN0_LO), .WIN0_HI(WIN0_HI),
                      .WIN1_LO(WIN1_LO), .WIN1_HI(WIN1_HI)) u_cap_a (
      .clk(clk), .iRst_n(iRst_n), .xzcs(bus.xzcs_a), .we(bus.we_a),
      .addr(bus.addr_a), .data(bus.data_a), .commit(vld_a), .word(word_a));

   dpfm_bus_capture #(.DW(DW), .AW(AW), .WIN0_LO(WIN0_LO), .WIN0_HI(WIN0_HI),
                      .WIN1_LO(WIN1_LO), .WIN1_HI(WIN1_HI)) u_cap_b (
      .clk(clk), .iRst_n(iRst_n), .xzcs(bus.xzcs_b), .we(bus.we_b),
      .addr(bus.addr_b), .data(bus.data_b), .commit(vld_b), .word(word_b));

   // --- stage p0: arbitrated word, B wins a collision and A waits one cycle
   logic          pend_vld;
   logic [DW-1:0] pend_word;
   logic          vld_p0, word_ok;
   logic [DW-1:0] word_p0;

   // Pick the word to parse this cycle
   always_comb begin
      vld_p0  = pend_vld | vld_b | vld_a;
      word_p0 = pend_vld ? pend_word : (vld_b ? word_b : word_a);
      word_ok = vld_p0 & ~iClr;
   end

   // Hold A's word when both buses commit together
   always_ff @(posedge clk or negedge iRst_n) begin
      if (!iRst_n) begin
         pend_vld  <= 1'b0;
         pend_word <= '0;
      end else begin
         pend_vld <= vld_a & vld_b;
         if (vld_a & vld_b) pend_word <= word_a;
      end
   end

   dpfm_state_t   state_q, state_d;
   logic [DW-1:0] rem_q, prev_q;
   logic          hist_vld;
   logic [17:0]   idle_q;
   logic          tmo;
   logic          done_ev, err_ev, seq_ev, len_ld, pay_ev, m0_set, m1_set;

   assign tmo    = (state_q != HUNT) && !vld_p0 && (idle_q == TIMEOUT);
   assign oState = state_q;

   // Parser state register
   always_ff @(posedge clk or negedge iRst_n) begin
      if (!iRst_n) state_q <= HUNT;
      else         state_q <= state_d;
   end

   // Parser next-state
   always_comb begin
      state_d = state_q;
      if (iClr || tmo) begin
         state_d = HUNT;
      end else if (word_ok) begin
         case (state_q)
            HUNT:    if (word_p0 == SYNC) state_d = SYNC1;
            SYNC1:   state_d = (word_p0 == SYNC) ? LEN : HUNT;
            LEN:     if (word_p0 != SYNC) state_d = (word_p0 > MAXLEN_W) ? HUNT : SEQ;
            SEQ:     state_d = (rem_q == '0) ? HUNT : PAY;
            PAY:     if (rem_q == DW'(1)) state_d = HUNT;
            default: state_d = HUNT;
         endcase
      end
   end

   // Parser actions for the current word
   always_comb begin
      done_ev = 1'b0;
      err_ev  = 1'b0;
      seq_ev  = 1'b0;
      len_ld  = 1'b0;
      pay_ev  = 1'b0;
      m0_set  = 1'b0;
      m1_set  = 1'b0;
      if (tmo) begin
         err_ev = 1'b1;
      end else if (word_ok) begin
         case (state_q)
            LEN: if (word_p0 != SYNC) begin
               if (word_p0 > MAXLEN_W) err_ev = 1'b1;
               else                    len_ld = 1'b1;
            end
            SEQ: begin
               seq_ev  = 1'b1;
               done_ev = (rem_q == '0);
            end
            PAY: begin
               pay_ev  = 1'b1;
               m0_set  = (word_p0 == MATCH0);
               m1_set  = (word_p0 == MATCH1);
               done_ev = (rem_q == DW'(1));
            end
            default: ;
         endcase
      end
   end

   // Idle watchdog, restarts on every parsed word and whenever hunting
   always_ff @(posedge clk or negedge iRst_n) begin
      if (!iRst_n)                           idle_q <= '0;
      else if (state_q == HUNT || vld_p0)    idle_q <= '0;
      else                                   idle_q <= idle_q + 1'b1;
   end

   // Status flags, counters, length and sequence history
   always_ff @(posedge clk or negedge iRst_n) begin
      if (!iRst_n) begin
         oSeqOk     <= 1'b0;
         oMatch0    <= 1'b0;
         oMatch1    <= 1'b0;
         oFrameDone <= 1'b0;
         oErr       <= 1'b0;
         oFrameCnt  <= '0;
         oErrCnt    <= '0;
         rem_q      <= '0;
         prev_q     <= '0;
         hist_vld   <= 1'b0;
      end else if (iClr) begin
         oSeqOk     <= 1'b0;
         oMatch0    <= 1'b0;
         oMatch1    <= 1'b0;
         oFrameDone <= 1'b0;
         oErr       <= 1'b0;
         oFrameCnt  <= '0;
         oErrCnt    <= '0;
         hist_vld   <= 1'b0;
      end else begin
         oFrameDone <= done_ev;
         oErr       <= err_ev;
         if (done_ev) oFrameCnt <= sat_inc(oFrameCnt);
         if (err_ev)  oErrCnt   <= sat_inc(oErrCnt);
         if (m0_set)  oMatch0   <= 1'b1;
         if (m1_set)  oMatch1   <= 1'b1;
         if (len_ld)  rem_q     <= word_p0;
         if (pay_ev)  rem_q     <= rem_q - 1'b1;
         if (seq_ev) begin
            oSeqOk   <= hist_vld && (word_p0 == DW'(prev_q + 1'b1));
            prev_q   <= word_p0;
            hist_vld <= 1'b1;
         end
      end
   end

endmodule
